conditional_3d_array_demux: RTL and testbench

Registered one-to-two steering stage for 3D arrays: accepts one `ROWS x COLS x BIT_WIDTH` array per handshake and delivers it to exactly one of two output ports, selected by `condition` sampled at acceptance. It is the inverse counterpart to the conditional 3D array select in the array-operations library, fanning a single stream out to two consumers instead of merging two sources into one. It provides a one-entry buffer with valid/ready flow control and per-port transfer counters.

---
 rtl/conditional_3d_array_demux.sv | 101 ++++++++++
 tb/tb_conditional_3d_array_demux.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/conditional_3d_array_demux.sv
// conditional_3d_array_demux
// Registered one-to-two steering stage for ROWS x COLS x BIT_WIDTH arrays.
// One-entry buffer with valid/ready flow control; the destination port is
// latched from `condition` on the accepting edge. Per-port transfer counters
// wrap modulo 2^COUNT_WIDTH.
// Optional build macro: CONDITIONAL_3D_ARRAY_DEMUX_ZERO_IDLE_EN
//   defined   -> a port whose valid is low drives an all-zero array
//   undefined -> both ports always show the buffered array
module conditional_3d_array_demux #(
  parameter int BIT_WIDTH   = 4,
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] in,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     condition,
  output logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] out_true,
  output logic                                     out_true_valid,
  input  logic                                     out_true_ready,
  output logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] out_false,
  output logic                                     out_false_valid,
  input  logic                                     out_false_ready,
  output logic [COUNT_WIDTH-1:0]                   count_true,
  output logic [COUNT_WIDTH-1:0]                   count_false
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                                   state_q, state_d;
  logic [ROWS-1:0][COLS-1:0][BIT_WIDTH-1:0] data_q, data_d;
  logic                                     dst_q, dst_d;
  logic [COUNT_WIDTH-1:0]                   cnt_t_q, cnt_t_d;
  logic [COUNT_WIDTH-1:0]                   cnt_f_q, cnt_f_d;

  logic full, sel_ready, accept, xfer_t, xfer_f;

  // Handshake decode: the buffer frees up on the same edge the selected
  // consumer takes it, so in_ready follows the selected ready while FULL.
  always_comb begin
    full            = (state_q == FULL);
    sel_ready       = dst_q ? out_true_ready : out_false_ready;
    in_ready        = !full || sel_ready;
    accept          = in_valid && in_ready;
    out_true_valid  = full && dst_q;
    out_false_valid = full && !dst_q;
    xfer_t          = out_true_valid && out_true_ready;
    xfer_f          = out_false_valid && out_false_ready;
  end

  // Next-state: load on accept (also covers drain+refill), else drain to EMPTY.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dst_d   = dst_q;
    cnt_t_d = cnt_t_q + {{(COUNT_WIDTH-1){1'b0}}, xfer_t};
    cnt_f_d = cnt_f_q + {{(COUNT_WIDTH-1){1'b0}}, xfer_f};
    if (accept) begin
      state_d = FULL;
      data_d  = in;
      dst_d   = condition;
    end else if (full && sel_ready) begin
      state_d = EMPTY;
    end
  end

  // State register; reset wins over any pending load or transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      dst_q   <= 1'b0;
      cnt_t_q <= '0;
      cnt_f_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dst_q   <= dst_d;
      cnt_t_q <= cnt_t_d;
      cnt_f_q <= cnt_f_d;
    end
  end

  assign count_true  = cnt_t_q;
  assign count_false = cnt_f_q;

  // Output arrays: per-row masking of idle ports, or straight buffer fan-out.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
`ifdef CONDITIONAL_3D_ARRAY_DEMUX_ZERO_IDLE_EN
    assign out_true[r]  = out_true_valid  ? data_q[r] : '0;
    assign out_false[r] = out_false_valid ? data_q[r] : '0;
`else
    assign out_true[r]  = data_q[r];
    assign out_false[r] = data_q[r];
`endif
  end

endmodule

// File: tb/tb_conditional_3d_array_demux.sv
// Directed bench for conditional_3d_array_demux: default instance plus a
// COUNT_WIDTH=2 instance sharing the same stimulus for the wrap check.
module tb_conditional_3d_array_demux;
  localparam int BW = 4, R = 8, C = 8;
  typedef logic [R-1:0][C-1:0][BW-1:0] arr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, in_valid, condition, out_true_ready, out_false_ready;
  arr_t in_arr;
  logic in_ready, out_true_valid, out_false_valid;
  arr_t out_true, out_false;
  logic [7:0] count_true, count_false;

  logic in_ready2, out_true_valid2, out_false_valid2;
  arr_t out_true2, out_false2;
  logic [1:0] count_true2, count_false2;

  conditional_3d_array_demux #(.BIT_WIDTH(BW), .ROWS(R), .COLS(C), .COUNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in(in_arr), .in_valid(in_valid), .in_ready(in_ready),
    .condition(condition), .out_true(out_true), .out_true_valid(out_true_valid),
    .out_true_ready(out_true_ready), .out_false(out_false),
    .out_false_valid(out_false_valid), .out_false_ready(out_false_ready),
    .count_true(count_true), .count_false(count_false));

  conditional_3d_array_demux #(.BIT_WIDTH(BW), .ROWS(R), .COLS(C), .COUNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in(in_arr), .in_valid(in_valid), .in_ready(in_ready2),
    .condition(condition), .out_true(out_true2), .out_true_valid(out_true_valid2),
    .out_true_ready(out_true_ready), .out_false(out_false2),
    .out_false_valid(out_false_valid2), .out_false_ready(out_false_ready),
    .count_true(count_true2), .count_false(count_false2));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Element (r,c) = (r*C + c + k) & 4'hF
  function automatic arr_t pattern(input int k);
    arr_t a;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        a[r][c] = 4'((r * C + c + k) & 15);
    return a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  arr_t p0, p1, p2, pk;
  logic cnd;

  initial begin
    rst = 1'b1; in_valid = 1'b0; condition = 1'b0; in_arr = '0;
    out_true_ready = 1'b0; out_false_ready = 1'b0;
    step(); step();
    rst = 1'b0; #1;

    // Reset / idle
    chk("rst_in_ready", in_ready, 1);
    chk("rst_tv", out_true_valid, 0);
    chk("rst_fv", out_false_valid, 0);
    chk("rst_ct", count_true, 0);
    chk("rst_cf", count_false, 0);
    chk("rst_out_true", out_true, 0);
    chk("rst_out_false", out_false, 0);

    // Single transfer to the true port
    p0 = pattern(0);
    in_arr = p0; condition = 1'b1; in_valid = 1'b1; out_true_ready = 1'b1;
    step();
    in_valid = 1'b0; condition = 1'b0; in_arr = '0; #1;
    chk("single_tv", out_true_valid, 1);
    chk("single_fv", out_false_valid, 0);
    chk("single_data", out_true, p0);
    chk("single_ct_pre", count_true, 0);
    step();
    chk("single_ct", count_true, 1);
    chk("single_tv_done", out_true_valid, 0);
    chk("single_in_ready", in_ready, 1);

    // Back-pressure on the false port
    p1 = ~pattern(3); p2 = pattern(7);
    in_arr = p1; condition = 1'b0; in_valid = 1'b1; out_false_ready = 1'b0;
    step();
    in_arr = p2; condition = 1'b1; #1;   // held valid, must not be taken
    for (int i = 0; i < 5; i++) begin
      out_true_ready = i[0];
      #1;
      chk("bp_in_ready", in_ready, 0);
      chk("bp_fv", out_false_valid, 1);
      chk("bp_tv", out_true_valid, 0);
      chk("bp_data", out_false, p1);
      chk("bp_cf", count_false, 0);
      step();
    end
    in_valid = 1'b0; out_false_ready = 1'b1; #1;
    chk("bp_ready_comb", in_ready, 1);
    step();
    chk("bp_cf_done", count_false, 1);
    chk("bp_fv_done", out_false_valid, 0);
    step();
    chk("bp_cf_once", count_false, 1);
    chk("bp_ct_same", count_true, 1);

    // Streaming, alternating routes, from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    out_true_ready = 1'b1; out_false_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      pk = pattern(i + 1); cnd = (i % 2 == 0);
      in_arr = pk; condition = cnd; in_valid = 1'b1;
      step();
      chk("st_tv", out_true_valid, cnd);
      chk("st_fv", out_false_valid, !cnd);
      chk("st_data", cnd ? out_true : out_false, pk);
      chk("st_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("st_ct", count_true, 8);
    chk("st_cf", count_false, 8);
    chk("st_ct2", count_true2, 0);
    chk("st_cf2", count_false2, 0);

    // Counter wrap with COUNT_WIDTH=2
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_arr = pattern(i); condition = 1'b1; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    chk("wrap_ct8", count_true, 5);
    chk("wrap_ct2", count_true2, 1);

    // Mid-operation reset while FULL with ready low
    out_true_ready = 1'b0;
    in_arr = pattern(9); condition = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0; #1;
    chk("mr_full", out_true_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0; out_true_ready = 1'b1; #1;
    chk("mr_tv", out_true_valid, 0);
    chk("mr_fv", out_false_valid, 0);
    chk("mr_ct", count_true, 0);
    chk("mr_cf", count_false, 0);
    chk("mr_in_ready", in_ready, 1);
    step();
    chk("mr_no_deliver", count_true, 0);
    chk("mr_tv_after", out_true_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
